// File: rtl/avg_pwr_est_pkg.sv
// avg_pwr_pkg: shared types and constants for the average power estimator.
// Optional AVG_PWR_ROUND_EN selects rounded normalisation in avg_pwr_est.
package avg_pwr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int unsigned MAP_GAIN_DEF = 32'd81920;
   localparam int GAIN_WID = 32;

   function automatic int prod_msb(input int w);
      return 2 * w - 2;
   endfunction

   function automatic int prod_lsb(input int w);
      return w - 1;
   endfunction

endpackage

// File: rtl/avg_pwr_est_abs_sq.sv
// abs_sq: saturated magnitude and fractional square of a 1s(W-1) sample.
module abs_sq
   import avg_pwr_pkg::*;
#(
   parameter int IN_WID = 18
) (
   input  logic signed [IN_WID-1:0] dec_var,
   output logic        [IN_WID-1:0] abs_val,
   output logic        [IN_WID-1:0] sq_val
);

   localparam int PMSB = prod_msb(IN_WID);
   localparam int PLSB = prod_lsb(IN_WID);
   localparam logic [IN_WID-1:0] MAX_POS  = {1'b0, {(IN_WID-1){1'b1}}};
   localparam logic [IN_WID-1:0] MOST_NEG = {1'b1, {(IN_WID-1){1'b0}}};

   logic [2*IN_WID-1:0] prod;
   logic                unused_bits;

   always_comb begin
      if (dec_var == MOST_NEG)
         abs_val = MAX_POS;
      else if (dec_var[IN_WID-1])
         abs_val = -dec_var;
      else
         abs_val = dec_var;
   end

   assign prod   = {{IN_WID{1'b0}}, abs_val} * {{IN_WID{1'b0}}, abs_val};
   assign sq_val = prod[PMSB:PLSB];

   assign unused_bits = ^{prod[2*IN_WID-1], prod[PLSB-1:0]};

endmodule

// File: rtl/avg_pwr_est.sv
// avg_pwr_est: windowed mean |x| and mean x^2 with mapper power estimate.
// Define AVG_PWR_ROUND_EN for rounded (saturating) window normalisation.
module avg_pwr_est
   import avg_pwr_pkg::*;
#(
   parameter int          IN_WID   = 18,
   parameter int          LOG2_WIN = 4,
   parameter int unsigned MAP_GAIN = MAP_GAIN_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sym_clk_en,
   input  logic signed [IN_WID-1:0] dec_var,
   input  logic                     start,
   input  logic                     continuous,
   output logic signed [IN_WID-1:0] ref_lvl,
   output logic signed [IN_WID-1:0] avg_pwr,
   output logic signed [IN_WID-1:0] map_out_pwr,
   output logic                     meas_valid,
   output logic                     busy
);

   localparam int AW   = IN_WID + LOG2_WIN;
   localparam int PW   = IN_WID + GAIN_WID;
   localparam int PMSB = prod_msb(IN_WID);
   localparam int PLSB = prod_lsb(IN_WID);
   localparam logic [GAIN_WID-1:0] GAIN = GAIN_WID'(MAP_GAIN);

   state_t              state;
   state_t              nxt;
   logic [LOG2_WIN-1:0] cnt;
   logic [AW-1:0]       mag_acc;
   logic [AW-1:0]       sq_acc;
   logic [AW-1:0]       mag_snap;
   logic [AW-1:0]       sq_snap;
   logic                snap_vld;
   logic                s1_vld;
   logic [IN_WID-1:0]   abs_val;
   logic [IN_WID-1:0]   sq_val;
   logic [AW-1:0]       abs_ext;
   logic [AW-1:0]       sq_ext;
   logic [IN_WID-1:0]   mag_norm;
   logic [IN_WID-1:0]   sq_norm;
   logic [2*IN_WID-1:0] ref_sq;
   logic [IN_WID-1:0]   ref_sq_s;
   logic [PW-1:0]       gain_prod;
   logic                take;
   logic                last;
   logic                unused_bits;

   abs_sq #(
      .IN_WID (IN_WID)
   ) u_abs_sq (
      .dec_var (dec_var),
      .abs_val (abs_val),
      .sq_val  (sq_val)
   );

   assign abs_ext = {{LOG2_WIN{1'b0}}, abs_val};
   assign sq_ext  = {{LOG2_WIN{1'b0}}, sq_val};

   // start always claims a coincident sample as sample 0
   assign take = sym_clk_en && (start || state == ACC);
   assign last = sym_clk_en && !start && state == ACC && cnt == '1;
   assign busy = (state != IDLE);

   always_comb begin
      nxt = state;
      if (start) begin
         nxt = ACC;
      end else begin
         unique case (state)
            IDLE:  nxt = IDLE;
            ACC:   if (last && !continuous) nxt = DRAIN;
            DRAIN: if (s1_vld) nxt = IDLE;
            default: nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         mag_acc  <= '0;
         sq_acc   <= '0;
         mag_snap <= '0;
         sq_snap  <= '0;
         snap_vld <= 1'b0;
      end else begin
         state    <= nxt;
         snap_vld <= last;
         if (start) begin
            cnt     <= take ? LOG2_WIN'(1) : '0;
            mag_acc <= take ? abs_ext : '0;
            sq_acc  <= take ? sq_ext : '0;
         end else if (last) begin
            mag_snap <= mag_acc + abs_ext;
            sq_snap  <= sq_acc + sq_ext;
            mag_acc  <= '0;
            sq_acc   <= '0;
            cnt      <= '0;
         end else if (take) begin
            mag_acc <= mag_acc + abs_ext;
            sq_acc  <= sq_acc + sq_ext;
            cnt     <= cnt + LOG2_WIN'(1);
         end
      end
   end

`ifdef AVG_PWR_ROUND_EN
   localparam logic [IN_WID:0] MAX_POS = {2'b00, {(IN_WID-1){1'b1}}};
   localparam logic [AW:0]     HALF    = (AW+1)'(1) << (LOG2_WIN-1);

   logic [AW:0] mag_rnd;
   logic [AW:0] sq_rnd;

   assign mag_rnd  = {1'b0, mag_snap} + HALF;
   assign sq_rnd   = {1'b0, sq_snap} + HALF;
   assign mag_norm = (mag_rnd[AW:LOG2_WIN] > MAX_POS) ?
                     MAX_POS[IN_WID-1:0] : mag_rnd[AW-1:LOG2_WIN];
   assign sq_norm  = (sq_rnd[AW:LOG2_WIN] > MAX_POS) ?
                     MAX_POS[IN_WID-1:0] : sq_rnd[AW-1:LOG2_WIN];
   assign unused_bits = ^{mag_rnd[LOG2_WIN-1:0], sq_rnd[LOG2_WIN-1:0],
                          gain_prod[PW-1:PMSB+1], gain_prod[PLSB-1:0],
                          ref_sq[2*IN_WID-1], ref_sq[PLSB-1:0]};
`else
   assign mag_norm = mag_snap[AW-1:LOG2_WIN];
   assign sq_norm  = sq_snap[AW-1:LOG2_WIN];
   assign unused_bits = ^{mag_snap[LOG2_WIN-1:0], sq_snap[LOG2_WIN-1:0],
                          gain_prod[PW-1:PMSB+1], gain_prod[PLSB-1:0],
                          ref_sq[2*IN_WID-1], ref_sq[PLSB-1:0]};
`endif

   assign ref_sq    = {{IN_WID{1'b0}}, ref_lvl} * {{IN_WID{1'b0}}, ref_lvl};
   assign ref_sq_s  = ref_sq[PMSB:PLSB];
   assign gain_prod = {{GAIN_WID{1'b0}}, ref_sq_s} * {{IN_WID{1'b0}}, GAIN};

   // two-stage result pipeline; outputs only move on their valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_vld      <= 1'b0;
         ref_lvl     <= '0;
         avg_pwr     <= '0;
         map_out_pwr <= '0;
         meas_valid  <= 1'b0;
      end else begin
         s1_vld     <= snap_vld;
         meas_valid <= s1_vld;
         if (snap_vld) begin
            ref_lvl <= mag_norm;
            avg_pwr <= sq_norm;
         end
         if (s1_vld)
            map_out_pwr <= gain_prod[PMSB:PLSB];
      end
   end

endmodule

// File: tb/tb_avg_pwr_est.sv
// tb_avg_pwr_est: randomized windows checked against an arithmetic model.
module tb_avg_pwr_est;

   localparam int     W    = 18;
   localparam int     L    = 2;
   localparam int     WIN  = 4;
   localparam longint GAIN = 81920;
   localparam longint MAXP = (64'sd1 <<< (W-1)) - 1;

   logic                clk = 1'b0;
   logic                reset;
   logic                sym_clk_en;
   logic signed [W-1:0] dec_var;
   logic                start;
   logic                continuous;
   logic signed [W-1:0] ref_lvl;
   logic signed [W-1:0] avg_pwr;
   logic signed [W-1:0] map_out_pwr;
   logic                meas_valid;
   logic                busy;

   int     total = 0;
   int     bad   = 0;
   longint cyc_n = 0;
   longint last_r = 0;
   longint last_a = 0;
   longint last_m = 0;

   always #5 clk = ~clk;

   avg_pwr_est #(
      .IN_WID   (W),
      .LOG2_WIN (L),
      .MAP_GAIN (32'd81920)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sym_clk_en  (sym_clk_en),
      .dec_var     (dec_var),
      .start       (start),
      .continuous  (continuous),
      .ref_lvl     (ref_lvl),
      .avg_pwr     (avg_pwr),
      .map_out_pwr (map_out_pwr),
      .meas_valid  (meas_valid),
      .busy        (busy)
   );

   function automatic longint m_abs(input longint v);
      if (v == -(64'sd1 <<< (W-1))) return MAXP;
      return (v < 0) ? -v : v;
   endfunction

   function automatic longint m_norm(input longint s);
      longint r;
`ifdef AVG_PWR_ROUND_EN
      r = (s + (64'sd1 <<< (L-1))) / WIN;
      if (r > MAXP) r = MAXP;
`else
      r = s / WIN;
`endif
      return r;
   endfunction

   task automatic model(input longint q[$], output longint r,
                        output longint a, output longint m);
      longint sm = 0;
      longint ss = 0;
      longint x;
      foreach (q[i]) begin
         x  = m_abs(q[i]);
         sm += x;
         ss += (x * x) / (64'sd1 <<< (W-1));
      end
      r = m_norm(sm);
      a = m_norm(ss);
      m = ((r * r) / (64'sd1 <<< (W-1))) * GAIN / (64'sd1 <<< (W-1));
      m = m % (64'sd1 <<< W);
   endtask

   function automatic longint rnd_val();
      return longint'($urandom_range(0, (1 << W) - 1)) - (64'sd1 <<< (W-1));
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic do_sample(input longint v);
      dec_var    = W'(v);
      sym_clk_en = 1'b1;
      cyc();
      sym_clk_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; sym_clk_en = 0; start = 0; continuous = 0; dec_var = '0;
      cyc(); cyc();
      total++;
      if ({ref_lvl, avg_pwr, map_out_pwr} !== '0) begin
         bad++;
         $display("FAIL reset_outs: got %0d/%0d/%0d want 0/0/0",
                  ref_lvl, avg_pwr, map_out_pwr);
      end
      total++;
      if (meas_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags: got mv=%b busy=%b want 0/0", meas_valid, busy);
      end
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_window(input string name, input longint q[$],
                              input bit with_start, input int max_gap);
      longint er, ea, em;
      int     i0;
      model(q, er, ea, em);
      start = 1'b1;
      i0 = 0;
      if (with_start) begin
         sym_clk_en = 1'b1;
         dec_var    = W'(q[0]);
         i0 = 1;
      end
      cyc();
      start = 1'b0; sym_clk_en = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++; $display("FAIL %s_busy_start: got %b want 1", name, busy);
      end
      for (int i = i0; i < WIN; i++) begin
         repeat ($urandom_range(0, max_gap)) begin
            dec_var = W'(rnd_val());
            cyc();
         end
         do_sample(q[i]);
      end
      total++;
      if (meas_valid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL %s_drain: got mv=%b busy=%b want 0/1", name, meas_valid, busy);
      end
      cyc();
      total++;
      if (meas_valid !== 1'b0) begin
         bad++; $display("FAIL %s_early: got mv=%b want 0", name, meas_valid);
      end
      cyc();
      total++;
      if (meas_valid !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s_pulse: got mv=%b busy=%b want 1/0", name, meas_valid, busy);
      end
      total++;
      if (ref_lvl !== er || avg_pwr !== ea || map_out_pwr !== em) begin
         bad++;
         $display("FAIL %s_vals: got %0d/%0d/%0d want %0d/%0d/%0d",
                  name, ref_lvl, avg_pwr, map_out_pwr, er, ea, em);
      end
      cyc();
      total++;
      if (meas_valid !== 1'b0) begin
         bad++; $display("FAIL %s_one_cycle: got mv=%b want 0", name, meas_valid);
      end
      last_r = er; last_a = ea; last_m = em;
   endtask

   task automatic test_directed();
      longint q[$];
      q = '{65536, 65536, 65536, 65536};
      test_window("same", q, 0, 0);
      total++;
      if (ref_lvl !== 65536 || avg_pwr !== 32768 || map_out_pwr !== 20480) begin
         bad++;
         $display("FAIL same_const: got %0d/%0d/%0d want 65536/32768/20480",
                  ref_lvl, avg_pwr, map_out_pwr);
      end
      q = '{65536, -65536, 65536, -65536};
      test_window("alt", q, 0, 1);
      total++;
      if (ref_lvl !== 65536 || avg_pwr !== 32768) begin
         bad++;
         $display("FAIL alt_const: got %0d/%0d want 65536/32768", ref_lvl, avg_pwr);
      end
      q = '{-131072, -131072, -131072, -131072};
      test_window("neg", q, 1, 0);
      total++;
      if (ref_lvl !== 131071 || avg_pwr !== 131070) begin
         bad++;
         $display("FAIL neg_const: got %0d/%0d want 131071/131070", ref_lvl, avg_pwr);
      end
      q = '{1, 2, 3, 4};
      test_window("small", q, 0, 2);
      total++;
`ifdef AVG_PWR_ROUND_EN
      if (ref_lvl !== 3) begin
         bad++; $display("FAIL small_round: got %0d want 3", ref_lvl);
      end
`else
      if (ref_lvl !== 2) begin
         bad++; $display("FAIL small_trunc: got %0d want 2", ref_lvl);
      end
`endif
   endtask

   task automatic test_random();
      longint q[$];
      for (int w = 0; w < 8; w++) begin
         q = {};
         for (int i = 0; i < WIN; i++) q.push_back(rnd_val());
         test_window($sformatf("rnd%0d", w), q, 1'($urandom_range(0, 1)), 3);
      end
   endtask

   task automatic test_hold_idle();
      for (int i = 0; i < 10; i++) begin
         sym_clk_en = 1'($urandom_range(0, 1));
         dec_var    = W'(rnd_val());
         cyc();
         total++;
         if (meas_valid !== 1'b0 || busy !== 1'b0 || ref_lvl !== last_r ||
             avg_pwr !== last_a || map_out_pwr !== last_m) begin
            bad++;
            $display("FAIL idle_hold: got mv=%b busy=%b %0d/%0d/%0d want 0/0 %0d/%0d/%0d",
                     meas_valid, busy, ref_lvl, avg_pwr, map_out_pwr,
                     last_r, last_a, last_m);
         end
      end
      sym_clk_en = 1'b0;
   endtask

   task automatic test_continuous();
      longint q[$];
      longint exp_r[$], exp_a[$], exp_m[$], exp_c[$];
      longint er, ea, em, v;
      int     pulses = 0;
      bool_busy: begin end
      continuous = 1'b1;
      start = 1'b1; cyc(); start = 1'b0;
      for (int i = 0; i < 3 * WIN + 2; i++) begin
         if (i < 3 * WIN) begin
            v = rnd_val();
            q.push_back(v);
            do_sample(v);
            if (q.size() == WIN) begin
               model(q, er, ea, em);
               exp_r.push_back(er); exp_a.push_back(ea);
               exp_m.push_back(em); exp_c.push_back(cyc_n + 2);
               q = {};
            end
         end else begin
            cyc();
         end
         total++;
         if (busy !== 1'b1) begin
            bad++; $display("FAIL cont_busy: got %b want 1 at cycle %0d", busy, cyc_n);
         end
         if (meas_valid === 1'b1) begin
            pulses++;
            total++;
            if (exp_c.size() == 0) begin
               bad++; $display("FAIL cont_extra: got pulse at %0d want none", cyc_n);
            end else if (cyc_n !== exp_c[0] || ref_lvl !== exp_r[0] ||
                         avg_pwr !== exp_a[0] || map_out_pwr !== exp_m[0]) begin
               bad++;
               $display("FAIL cont_pulse: got c=%0d %0d/%0d/%0d want c=%0d %0d/%0d/%0d",
                        cyc_n, ref_lvl, avg_pwr, map_out_pwr,
                        exp_c[0], exp_r[0], exp_a[0], exp_m[0]);
            end
            if (exp_c.size() != 0) begin
               void'(exp_c.pop_front()); void'(exp_r.pop_front());
               void'(exp_a.pop_front()); void'(exp_m.pop_front());
            end
         end
      end
      total++;
      if (pulses !== 3) begin
         bad++; $display("FAIL cont_count: got %0d pulses want 3", pulses);
      end
   endtask

   task automatic test_restart();
      longint q[$];
      longint er, ea, em, v;
      int     seen = -1;
      do_sample(rnd_val());
      do_sample(rnd_val());
      start = 1'b1; cyc(); start = 1'b0;
      for (int i = 0; i < WIN; i++) begin
         v = rnd_val();
         q.push_back(v);
         do_sample(v);
         total++;
         if (meas_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL restart_early: got mv=%b busy=%b want 0/1 at sample %0d",
                     meas_valid, busy, i);
         end
      end
      model(q, er, ea, em);
      for (int k = 1; k <= 4 && seen < 0; k++) begin
         cyc();
         if (meas_valid === 1'b1) seen = k;
      end
      total++;
      if (seen !== 2) begin
         bad++; $display("FAIL restart_lat: got %0d cycles want 2", seen);
      end
      total++;
      if (ref_lvl !== er || avg_pwr !== ea || map_out_pwr !== em) begin
         bad++;
         $display("FAIL restart_vals: got %0d/%0d/%0d want %0d/%0d/%0d",
                  ref_lvl, avg_pwr, map_out_pwr, er, ea, em);
      end
      continuous = 1'b0;
   endtask

   task automatic test_reset_mid();
      start = 1'b1; cyc(); start = 1'b0;
      do_sample(rnd_val());
      do_sample(rnd_val());
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      total++;
      if ({ref_lvl, avg_pwr, map_out_pwr} !== '0 || meas_valid !== 1'b0 ||
          busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid: got %0d/%0d/%0d mv=%b busy=%b want all 0",
                  ref_lvl, avg_pwr, map_out_pwr, meas_valid, busy);
      end
      @(negedge clk) reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         do_sample(rnd_val());
         total++;
         if (meas_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_nostart: got mv=%b busy=%b want 0/0", meas_valid, busy);
         end
      end
      cyc(); cyc();
      total++;
      if (meas_valid !== 1'b0) begin
         bad++; $display("FAIL rst_nostart_tail: got mv=%b want 0", meas_valid);
      end
   endtask

   initial begin
      longint q[$];
      test_reset();
      test_directed();
      test_random();
      test_hold_idle();
      test_continuous();
      test_restart();
      test_reset_mid();
      q = '{rnd_val(), rnd_val(), rnd_val(), rnd_val()};
      test_window("post_rst", q, 1, 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
